imm_rot_encoder: RTL and testbench



---
 rtl/imm_rot_encoder.sv | 143 ++++++++++++++
 tb/tb_imm_rot_encoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/imm_rot_encoder.sv
// Iterative search for the canonical {rotate_imm, immed_8} encoding of a 32-bit constant.
// Optional MVN-form retry on ~value is enabled by defining IMM_INVERT_EN.
module imm_rot_encoder #(
    parameter int PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [11:0] shift_operand,
    output logic        inverted
);

    generate
        if (PER_CYCLE != 1 && PER_CYCLE != 2 && PER_CYCLE != 4 &&
            PER_CYCLE != 8 && PER_CYCLE != 16) begin : g_bad_per_cycle
            $error("imm_rot_encoder: PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

`ifdef IMM_INVERT_EN
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_INV_SEARCH, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;
`endif

    state_t      state, state_nxt;
    logic [31:0] v_q;
    logic [31:0] cand;
    logic [3:0]  r_base;
    logic [3:0]  r_c;
    logic [31:0] rot_c;
    logic        hit;
    logic [11:0] hit_op;
    logic        last_step;
    logic        in_search;
    logic        inv_q;

    function automatic logic [31:0] rol2(input logic [31:0] x, input logic [3:0] r);
        logic [63:0] d;
        d = {x, x} << {r, 1'b0};
        return d[63:32];
    endfunction

`ifdef IMM_INVERT_EN
    assign cand      = (state == S_INV_SEARCH) ? ~v_q : v_q;
    assign in_search = (state == S_SEARCH) || (state == S_INV_SEARCH);
`else
    assign cand      = v_q;
    assign in_search = (state == S_SEARCH);
`endif

    assign last_step = (r_base == 4'(16 - PER_CYCLE));

    // Test PER_CYCLE consecutive rotations; the lowest one that fits wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        hit    = 1'b0;
        hit_op = 12'h000;
        r_c    = 4'd0;
        rot_c  = 32'd0;
        for (int i = 0; i < PER_CYCLE; i++) begin
            r_c   = r_base + 4'(i);
            rot_c = rol2(cand, r_c);
            if (!hit && rot_c[31:8] == 24'd0) begin
                hit    = 1'b1;
                hit_op = {r_c, rot_c[7:0]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SEARCH;
            S_SEARCH: begin
                if (hit) state_nxt = S_DONE;
`ifdef IMM_INVERT_EN
                else if (last_step) state_nxt = S_INV_SEARCH;
`else
                else if (last_step) state_nxt = S_DONE;
`endif
            end
`ifdef IMM_INVERT_EN
            S_INV_SEARCH: if (hit || last_step) state_nxt = S_DONE;
`endif
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Datapath: latched operand, rotation cursor and the held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q           <= 32'd0;
            r_base        <= 4'd0;
            found         <= 1'b0;
            shift_operand <= 12'h000;
            inv_q         <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) begin
                v_q           <= value;
                r_base        <= 4'd0;
                found         <= 1'b0;
                shift_operand <= 12'h000;
                inv_q         <= 1'b0;
            end
        end else if (in_search) begin
            if (hit) begin
                found         <= 1'b1;
                shift_operand <= hit_op;
`ifdef IMM_INVERT_EN
                inv_q         <= (state == S_INV_SEARCH);
`endif
            end else if (last_step) begin
                r_base <= 4'd0;
            end else begin
                r_base <= r_base + 4'(PER_CYCLE);
            end
        end
    end

`ifdef IMM_INVERT_EN
    assign inverted = inv_q;
`else
    assign inverted = 1'b0;
`endif

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Directed bench for imm_rot_encoder: vector table on PER_CYCLE=1 plus multi-cycle corner cases.
// A second instance runs with PER_CYCLE=4.
module tb_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start4 = 1'b0;
    logic [31:0] value1 = 32'd0, value4 = 32'd0;
    logic        busy1, done1, found1, inv1;
    logic        busy4, done4, found4, inv4;
    logic [11:0] op1, op4;

    logic        sel4 = 1'b0;
    logic        m_busy, m_done, m_found, m_inv;
    logic [11:0] m_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_rot_encoder #(.PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .value(value1),
        .busy(busy1), .done(done1), .found(found1),
        .shift_operand(op1), .inverted(inv1)
    );

    imm_rot_encoder #(.PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .value(value4),
        .busy(busy4), .done(done4), .found(found4),
        .shift_operand(op4), .inverted(inv4)
    );

    assign m_busy  = sel4 ? busy4  : busy1;
    assign m_done  = sel4 ? done4  : done1;
    assign m_found = sel4 ? found4 : found1;
    assign m_inv   = sel4 ? inv4   : inv1;
    assign m_op    = sel4 ? op4    : op1;

    typedef struct {
        logic [31:0] value;
        int          n;
        logic        found;
        logic [11:0] op;
        logic        inv;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input logic [31:0] v);
        @(negedge clk);
        if (sel4) begin start4 = 1'b1; value4 = v; end
        else      begin start1 = 1'b1; value1 = v; end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        value1 = ~v;
        value4 = ~v;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_done && n < 40);
        check("done_timeout", {31'd0, m_done}, 32'd1);
    endtask

    task automatic run_vec(input vec_t t);
        int n;
        drive_start(t.value);
        check("busy_after_accept", {31'd0, m_busy}, 32'd1);
        check("found_cleared", {31'd0, m_found}, 32'd0);
        check("op_cleared", {20'd0, m_op}, 32'd0);
        wait_done(n);
        check("latency", n, t.n);
        check("found", {31'd0, m_found}, {31'd0, t.found});
        check("shift_operand", {20'd0, m_op}, {20'd0, t.op});
        check("inverted", {31'd0, m_inv}, {31'd0, t.inv});
        check("busy_in_done", {31'd0, m_busy}, 32'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, m_done}, 32'd0);
        check("busy_falls", {31'd0, m_busy}, 32'd0);
        check("found_held", {31'd0, m_found}, {31'd0, t.found});
        check("op_held", {20'd0, m_op}, {20'd0, t.op});
    endtask

    initial begin
        int n;

        vecs[0] = '{32'h0000_00FF, 1,  1'b1, 12'h0FF, 1'b0};
        vecs[1] = '{32'hFF00_0000, 5,  1'b1, 12'h4FF, 1'b0};
        vecs[2] = '{32'h0000_0104, 16, 1'b1, 12'hF41, 1'b0};
        vecs[3] = '{32'h0000_0000, 1,  1'b1, 12'h000, 1'b0};
        vecs[4] = '{32'hF000_000F, 3,  1'b1, 12'h2FF, 1'b0};
        vecs[5] = '{32'h0000_03FC, 16, 1'b1, 12'hFFF, 1'b0};
`ifdef IMM_INVERT_EN
        vecs[6] = '{32'h0000_0101, 32, 1'b0, 12'h000, 1'b0};
        vecs[7] = '{32'hFFFF_FF00, 17, 1'b1, 12'h0FF, 1'b1};
`else
        vecs[6] = '{32'h0000_0101, 16, 1'b0, 12'h000, 1'b0};
        vecs[7] = '{32'hFFFF_FF00, 16, 1'b0, 12'h000, 1'b0};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_done", {31'd0, done1}, 32'd0);
        check("rst_found", {31'd0, found1}, 32'd0);
        check("rst_op", {20'd0, op1}, 32'd0);
        check("rst_inv", {31'd0, inv1}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", {31'd0, busy1}, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // start with value 0 while busy must be ignored
        drive_start(32'h0000_0104);
        n = 0;
        @(posedge clk); #1; n++;
        start1 = 1'b1; value1 = 32'd0;
        @(posedge clk); #1; n++;
        start1 = 1'b0;
        while (!done1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("ign_latency", n, 16);
        check("ign_op", {20'd0, op1}, 32'h0000_0F41);
        check("ign_found", {31'd0, found1}, 32'd1);
        @(posedge clk); #1;
        check("ign_busy_falls", {31'd0, busy1}, 32'd0);

        // reset three cycles into a search aborts it with no done pulse
        drive_start(32'h0000_0104);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_done_early", {31'd0, done1}, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy1}, 32'd0);
        check("abort_done", {31'd0, done1}, 32'd0);
        check("abort_found", {31'd0, found1}, 32'd0);
        check("abort_op", {20'd0, op1}, 32'd0);
        check("abort_inv", {31'd0, inv1}, 32'd0);
        repeat (20) begin
            @(posedge clk); #1;
            check("abort_no_done_late", {31'd0, done1}, 32'd0);
        end

        // PER_CYCLE=4 instance
        sel4 = 1'b1;
        run_vec('{32'hFF00_0000, 2, 1'b1, 12'h4FF, 1'b0});
        run_vec('{32'h0000_0104, 4, 1'b1, 12'hF41, 1'b0});
        run_vec('{32'h0000_00FF, 1, 1'b1, 12'h0FF, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
